// File: rtl/traffic_stim_gen.sv
// Stimulus generator for a traffic-light FSM: reset pulse, LFSR-driven vehicle counts, pedestrian pulses, transition checker.
// Optional build macro STIM_TEST_MODE_EN: drives test_mode_o during the run and suppresses pedestrian pulses.
module traffic_stim_gen #(
    parameter int          NUM_APPROACH = 4,
    parameter int          COUNT_W      = 3,
    parameter int          RST_CYCLES   = 2,
    parameter int          PED_PERIOD   = 16,
    parameter int          RUN_CYCLES   = 1024,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                            clock_i,
    input  logic                            reset_n_i,
    input  logic                            enable_i,
    input  logic [NUM_APPROACH-1:0]         green_i,
    input  logic [15:0]                     transition_count_i,
    output logic                            fsm_reset_n_o,
    output logic [NUM_APPROACH*COUNT_W-1:0] vcount_o,
    output logic [1:0]                      ped_button_o,
    output logic                            test_mode_o,
    output logic                            done_o,
    output logic                            error_o
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int PED_W = $clog2(PED_PERIOD);
    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [PED_W-1:0]   PED_LAST = PED_W'(PED_PERIOD - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(RUN_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

`ifdef STIM_TEST_MODE_EN
    localparam logic TEST_MODE = 1'b1;
`else
    localparam logic TEST_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RST_PULSE, RUN, DONE} state_t;

    state_t                  state;
    logic [15:0]             lfsr;
    logic [RST_W-1:0]        rst_cnt;
    logic [RUN_W-1:0]        run_cnt;
    logic [PED_W-1:0]        ped_cnt;
    logic                    ped_ew;
    logic [15:0]             prev_tc;
    logic                    have_prev;
    logic [NUM_APPROACH-1:0] arrival;
    logic [15:0]             tc_delta;
    logic                    lfsr_fb;
    logic                    run_step;
    logic                    ped_fire;

    assign run_step = (state == RUN) && enable_i;
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // Modular difference makes 16'hFFFF -> 0 a legal +1 step and any decrease a huge delta.
    assign tc_delta = transition_count_i - prev_tc;
    assign ped_fire = run_step && (ped_cnt == PED_LAST);

    assign ped_button_o = (ped_fire && !TEST_MODE) ? (ped_ew ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        arrival = '0;
        for (int k = 0; k < NUM_APPROACH; k++) begin
            arrival[k] = lfsr[k] & lfsr[k+8];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            fsm_reset_n_o <= 1'b1;
            test_mode_o   <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            lfsr          <= SEED;
            rst_cnt       <= '0;
            run_cnt       <= '0;
            ped_cnt       <= '0;
            ped_ew        <= 1'b0;
            prev_tc       <= '0;
            have_prev     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state         <= RST_PULSE;
                        fsm_reset_n_o <= 1'b0;
                        test_mode_o   <= TEST_MODE;
                        rst_cnt       <= '0;
                    end
                end
                RST_PULSE: begin
                    if (rst_cnt == RST_LAST) begin
                        state         <= RUN;
                        fsm_reset_n_o <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (enable_i) begin
                        lfsr      <= {lfsr[14:0], lfsr_fb};
                        prev_tc   <= transition_count_i;
                        have_prev <= 1'b1;
                        if (have_prev && (tc_delta > 16'd1)) begin
                            error_o <= 1'b1;
                        end
                        if (ped_cnt == PED_LAST) begin
                            ped_cnt <= '0;
                            ped_ew  <= ~ped_ew;
                        end else begin
                            ped_cnt <= ped_cnt + 1'b1;
                        end
                        if (run_cnt == RUN_LAST) begin
                            state       <= DONE;
                            done_o      <= 1'b1;
                            test_mode_o <= 1'b0;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One saturating up/down counter per approach, only moving on enabled RUN clocks.
    for (genvar k = 0; k < NUM_APPROACH; k++) begin : g_count
        logic [COUNT_W-1:0] cnt;

        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt <= '0;
            end else if (run_step) begin
                if (arrival[k] && !green_i[k] && (cnt != CNT_MAX)) begin
                    cnt <= cnt + 1'b1;
                end else if (green_i[k] && !arrival[k] && (cnt != '0)) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end

        assign vcount_o[k*COUNT_W +: COUNT_W] = cnt;
    end

endmodule

// File: tb/tb_traffic_stim_gen.sv
// Self-checking bench for traffic_stim_gen: scoreboarded counts, checker vector table, and pedestrian/done timing on a short-run instance.
module tb_traffic_stim_gen;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic        en_a = 1'b0;
    logic [3:0]  green_a = 4'b0;
    logic [15:0] tc_a = 16'd0;
    logic        fsm_rst_a, tm_a, done_a, err_a;
    logic [11:0] vcount_a;
    logic [1:0]  ped_a;

    logic        en_b = 1'b0;
    logic [3:0]  green_b = 4'b0;
    logic [15:0] tc_b = 16'd0;
    logic        fsm_rst_b, tm_b, done_b, err_b;
    logic [11:0] vcount_b;
    logic [1:0]  ped_b;

    traffic_stim_gen dut (
        .clock_i(clock), .reset_n_i(reset_n), .enable_i(en_a), .green_i(green_a),
        .transition_count_i(tc_a), .fsm_reset_n_o(fsm_rst_a), .vcount_o(vcount_a),
        .ped_button_o(ped_a), .test_mode_o(tm_a), .done_o(done_a), .error_o(err_a)
    );

    traffic_stim_gen #(.RUN_CYCLES(32), .PED_PERIOD(16)) dut_short (
        .clock_i(clock), .reset_n_i(reset_n), .enable_i(en_b), .green_i(green_b),
        .transition_count_i(tc_b), .fsm_reset_n_o(fsm_rst_b), .vcount_o(vcount_b),
        .ped_button_o(ped_b), .test_mode_o(tm_b), .done_o(done_b), .error_o(err_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] vcount;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        rst;
        logic [15:0] tc;
        logic        exp_err;
    } vec_t;
    vec_t vecs[10];

    logic [15:0] m_lfsr;
    logic [2:0]  m_cnt [4];
    logic [11:0] first_trace [30];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [11:0] packModel();
        logic [11:0] p;
        for (int k = 0; k < 4; k++) p[k*3 +: 3] = m_cnt[k];
        return p;
    endfunction

    task automatic modelStep(input logic [3:0] g);
        logic arr;
        for (int k = 0; k < 4; k++) begin
            arr = m_lfsr[k] & m_lfsr[k+8];
            if (arr && !g[k] && m_cnt[k] != 3'd7) m_cnt[k] = m_cnt[k] + 3'd1;
            else if (!arr && g[k] && m_cnt[k] != 3'd0) m_cnt[k] = m_cnt[k] - 3'd1;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    // Called at a negedge with the main instance in RUN; returns at the next negedge.
    task automatic applyStimulus(input logic en, input logic [3:0] g, input logic [15:0] tc, input logic exp_err);
        exp_t item;
        en_a = en;
        green_a = g;
        tc_a = tc;
        if (en) modelStep(g);
        sb.push_back('{packModel(), exp_err});
        @(posedge clock);
        #1;
        item = sb.pop_front();
        checkOutput("vcount", {20'd0, vcount_a}, {20'd0, item.vcount});
        checkOutput("error", {31'd0, err_a}, {31'd0, item.err});
        @(negedge clock);
    endtask

    task automatic startRunA();
        reset_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        green_a = 4'b0;
        tc_a = 16'd0;
        #1;
        checkOutput("rst_vcount", {20'd0, vcount_a}, 32'd0);
        checkOutput("rst_fsm_reset_n", {31'd0, fsm_rst_a}, 32'd1);
        checkOutput("rst_ped", {30'd0, ped_a}, 32'd0);
        checkOutput("rst_test_mode", {31'd0, tm_a}, 32'd0);
        checkOutput("rst_done", {31'd0, done_a}, 32'd0);
        checkOutput("rst_error", {31'd0, err_a}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        m_lfsr = 16'hACE1;
        for (int k = 0; k < 4; k++) m_cnt[k] = 3'd0;
        sb.delete();
        @(negedge clock);
        en_a = 1'b1;
        @(posedge clock); #1;
        checkOutput("rst_pulse_c1", {31'd0, fsm_rst_a}, 32'd0);
        checkOutput("test_mode_c1", {31'd0, tm_a}, 32'd0);
        @(posedge clock); #1;
        checkOutput("rst_pulse_c2", {31'd0, fsm_rst_a}, 32'd0);
        @(posedge clock); #1;
        checkOutput("run_entry_c3", {31'd0, fsm_rst_a}, 32'd1);
        @(negedge clock);
    endtask

    task automatic runShort(input int pause_at, input int pause_len);
        int n;
        int done_cycle;
        logic done_m;
        logic [1:0] exp_ped;
        reset_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        en_b = 1'b1;
        repeat (3) @(negedge clock);
        n = 0;
        done_m = 1'b0;
        done_cycle = -1;
        for (int cyc = 0; cyc < 32 + pause_len + 4; cyc++) begin
            en_b = (cyc < pause_at || cyc >= pause_at + pause_len) ? 1'b1 : (cyc % 2 == 0);
            if (cyc >= pause_at && cyc < pause_at + pause_len) en_b = 1'b0;
            if (done_m) en_b = cyc[0];
            #1;
            exp_ped = 2'b00;
            if (en_b && !done_m && ((n + 1) % 16 == 0)) exp_ped = (((n + 1) / 16) % 2 == 1) ? 2'b01 : 2'b10;
            checkOutput("ped_button", {30'd0, ped_b}, {30'd0, exp_ped});
            @(posedge clock); #1;
            if (en_b && !done_m) n++;
            done_m = (n == 32);
            checkOutput("done", {31'd0, done_b}, {31'd0, done_m});
            if (done_b && done_cycle < 0) done_cycle = cyc;
            @(negedge clock);
        end
        checkOutput("done_latency", done_cycle, 31 + pause_len);
        checkOutput("short_test_mode", {31'd0, tm_b}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'd5,     1'b0};
        vecs[1] = '{1'b0, 16'd6,     1'b0};
        vecs[2] = '{1'b0, 16'd6,     1'b0};
        vecs[3] = '{1'b0, 16'd8,     1'b1};
        vecs[4] = '{1'b0, 16'd9,     1'b1};
        vecs[5] = '{1'b1, 16'hFFFF,  1'b0};
        vecs[6] = '{1'b0, 16'd0,     1'b0};
        vecs[7] = '{1'b0, 16'd1,     1'b0};
        vecs[8] = '{1'b0, 16'd0,     1'b1};
        vecs[9] = '{1'b0, 16'd0,     1'b1};

        @(negedge clock);
        startRunA();

        // No greens: every approach fills up and pins at 7; a short pause in the middle must hold everything.
        for (int i = 0; i < 96; i++) begin
            applyStimulus(!(i >= 40 && i < 45), 4'b0000, 16'd0, 1'b0);
            if (i < 30) first_trace[i] = packModel();
        end
        for (int k = 0; k < 4; k++) checkOutput("sat_high", {29'd0, vcount_a[k*3 +: 3]}, 32'd7);

        for (int i = 0; i < 96; i++) applyStimulus(1'b1, 4'b1111, 16'd0, 1'b0);
        for (int k = 0; k < 4; k++) checkOutput("sat_low", {29'd0, vcount_a[k*3 +: 3]}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 4'($urandom_range(0, 15) & $urandom_range(0, 15)), 16'd0, 1'b0);
        end

        // Abort mid-run and replay: the count trace must match the first run cycle for cycle.
        startRunA();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 4'b0000, 16'd0, 1'b0);
            checkOutput("replay_trace", {20'd0, vcount_a}, {20'd0, first_trace[i]});
        end

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) startRunA();
            applyStimulus(1'b1, 4'b0000, vecs[i].tc, vecs[i].exp_err);
        end

        runShort(1000, 0);
        runShort(10, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_stim_gen.md
TRAFFIC_STIM_GEN -- requirements
Module: traffic_stim_gen

Interface
REQ-001 The block SHALL have parameter NUM_APPROACH, default 4, meaning number of traffic approaches (legal 2..8, even).
REQ-002 The block SHALL have parameter COUNT_W, default 3, meaning vehicle-count width per approach.
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, meaning FSM reset pulse length in clocks (legal >=1).
REQ-004 The block SHALL have parameter PED_PERIOD, default 16, meaning clocks between pedestrian pulses (legal >=2).
REQ-005 The block SHALL have parameter RUN_CYCLES, default 1024, meaning RUN duration in clocks.
REQ-006 The block SHALL have parameter SEED, default 16'hACE1, meaning nonzero LFSR seed.
REQ-007 Ports SHALL be: clock_i  in  1  single clock, rising edge; reset_n_i  in  1  asynchronous active-low reset.
REQ-008 Ports SHALL be: enable_i  in  1  start/continue; green_i  in  NUM_APPROACH  per-approach green from FSM; transition_count_i  in  16  FSM transition counter.
REQ-009 Ports SHALL be: fsm_reset_n_o  out  1  reset to FSM; vcount_o  out  NUM_APPROACH*COUNT_W  packed counts, approach k at bits [k*COUNT_W +: COUNT_W].
REQ-010 Ports SHALL be: ped_button_o  out  2  bit0 NS, bit1 EW; test_mode_o  out  1; done_o  out  1; error_o  out  1  sticky checker flag.

Function
REQ-011 The FSM SHALL have states IDLE, RST_PULSE, RUN, DONE.
REQ-012 IDLE->RST_PULSE SHALL occur on the first clock with enable_i=1; fsm_reset_n_o SHALL be 0 for exactly RST_CYCLES clocks in RST_PULSE, then RUN.
REQ-013 RUN->DONE SHALL occur after RUN_CYCLES enabled RUN clocks; DONE SHALL hold with done_o=1 until reset_n_i asserts.
REQ-014 In RUN with enable_i=0, LFSR, counts, timers and checker SHALL hold; RST_PULSE and DONE SHALL ignore enable_i.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL load SEED on reset and advance once per enabled RUN clock.
REQ-016 Arrival for approach k SHALL be lfsr[k] & lfsr[k+8] from the pre-advance value.
REQ-017 Each count SHALL +1 on arrival without green, -1 on green without arrival, hold on both or neither.
REQ-018 Counts SHALL saturate at 2^COUNT_W-1 and at 0 (no wrap).
REQ-019 ped_button_o SHALL emit a one-clock pulse every PED_PERIOD enabled RUN clocks, alternating NS first then EW; never both bits high.
REQ-020 Checker SHALL, in RUN after the first enabled clock, set error_o if transition_count_i decreases or increases by more than 1 between consecutive enabled clocks; 16'hFFFF->0 SHALL count as +1.
REQ-021 error_o SHALL stay 1 until reset_n_i; done_o and outputs other than ped pulses SHALL be registered.
REQ-022 Outside RUN, ped_button_o SHALL be 0 and counts SHALL hold.

Reset
REQ-023 On reset_n_i=0, immediately: state IDLE, fsm_reset_n_o=1, vcount_o=0, ped_button_o=0, test_mode_o=0, done_o=0, error_o=0, LFSR=SEED, timers 0.
REQ-024 Reset mid-RUN SHALL abort the run; restart requires enable_i and replays the identical sequence.

Configuration
REQ-025 With STIM_TEST_MODE_EN defined, test_mode_o SHALL be 1 in RUN and RST_PULSE and ped pulses SHALL be suppressed; undefined, test_mode_o SHALL be constant 0 and ped pulses per REQ-019.

Verification
REQ-026 Reset release, enable_i=1 at cycle 0 -> fsm_reset_n_o low cycles 1-2 (RST_CYCLES=2), RUN from cycle 3.
REQ-027 green_i=0 for 64 cycles, COUNT_W=3 -> every count reaches 7 and holds at 7.
REQ-028 green_i=all ones for 64 cycles -> every count reaches and stays 0.
REQ-029 transition_count_i 5,6,6,8 -> error_o=1 on the clock sampling 8, stays 1; sequence 16'hFFFF,0 -> error_o=0.
REQ-030 RUN_CYCLES=32, PED_PERIOD=16 -> ped pulses NS at RUN clock 16, EW at 32, done_o=1 after 32 enabled clocks; enable_i low 5 clocks mid-run delays done_o by 5.
REQ-031 reset_n_i low mid-RUN then re-enable -> vcount_o trace identical to first run.
